// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter: shift modes,
// per-stage control payload and the mapping of mux levels onto pipeline stages.
package shifter_pkg;

  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_t;

  typedef struct packed {
    shift_mode_t mode;
    logic        carry;
    logic        fill;
    logic        sign;
  } stage_ctrl_t;

  // Stage that holds mux level lvl when n_levels levels are spread over n_stages.
  function automatic int level_stage(input int lvl, input int n_stages, input int n_levels);
    return (lvl * n_stages) / n_levels;
  endfunction

  // Reserved encodings collapse to SLL at entry so later stages only see legal modes.
  function automatic shift_mode_t decode_mode(input logic [2:0] raw);
    case (raw)
      3'd1:    return SRL;
      3'd2:    return SRA;
      3'd3:    return ROL;
      3'd4:    return ROR;
      default: return SLL;
    endcase
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter: shifts or rotates by the
// fixed distance DIST when enabled and reports the last bit moved out as carry.
module shift_level
  import shifter_pkg::*;
#(
  parameter int nBITS = 32,
  parameter int DIST  = 1
) (
  input  logic [nBITS-1:0] data_i,
  input  logic             carry_i,
  input  shift_mode_t      mode_i,
  input  logic             en_i,
  input  logic             fill_i,
  input  logic             sign_i,
  output logic [nBITS-1:0] data_o,
  output logic             carry_o
);

  always_comb begin
    // NOTE: pass-through defaults up front keep every path assigned, so no latch is inferred.
    data_o  = data_i;
    carry_o = carry_i;
    if (en_i) begin
      case (mode_i)
        SRL: begin
          data_o  = {{DIST{fill_i}}, data_i[nBITS-1:DIST]};
          carry_o = data_i[DIST-1];
        end
        SRA: begin
          data_o  = {{DIST{sign_i}}, data_i[nBITS-1:DIST]};
          carry_o = data_i[DIST-1];
        end
        ROL: begin
          data_o  = {data_i[nBITS-DIST-1:0], data_i[nBITS-1:nBITS-DIST]};
          carry_o = data_i[nBITS-DIST];
        end
        ROR: begin
          data_o  = {data_i[DIST-1:0], data_i[nBITS-1:DIST]};
          carry_o = data_i[DIST-1];
        end
        default: begin
          data_o  = {data_i[nBITS-DIST-1:0], {DIST{fill_i}}};
          carry_o = data_i[nBITS-DIST];
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Elastic pipelined barrel shifter: log2(nBITS) mux levels, largest distance
// first, spread over nSTAGES registered stages with valid/ready handshakes.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int nBITS   = 32,
  parameter int nSTAGES = 2
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [nBITS-1:0]         In,
  input  logic [$clog2(nBITS)-1:0] ShiftAmount,
  input  logic [2:0]               Mode,
  input  logic                     ShiftIn,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [nBITS-1:0]         Out,
  output logic                     CarryOut
);

  localparam int L = $clog2(nBITS);

  typedef struct packed {
    logic [nBITS-1:0] data;
    logic [L-1:0]     amt;
    stage_ctrl_t      ctrl;
  } payload_t;

  payload_t stage_in [nSTAGES];
  payload_t stage_out[nSTAGES];
  payload_t lvl_in   [L];
  payload_t lvl_out  [L];
  payload_t pay_d    [nSTAGES];
  payload_t pay_q    [nSTAGES];

  logic [nSTAGES-1:0] valid_d, valid_q, advance;
  logic [nSTAGES:0]   valid_in;
  logic               ready_en_q;
  logic               all_full;

  assign stage_in[0] = '{
    data: In,
    amt:  ShiftAmount,
    ctrl: '{mode: decode_mode(Mode), carry: 1'b0, fill: ShiftIn, sign: In[nBITS-1]}
  };

  for (genvar s = 1; s < nSTAGES; s++) begin : g_stage_link
    assign stage_in[s] = pay_q[s-1];
  end

  for (genvar i = 0; i < L; i++) begin : g_level
    localparam int ST   = level_stage(i, nSTAGES, L);
    localparam int DIST = 1 << (L - 1 - i);

    logic [nBITS-1:0] data_sh;
    logic             carry_sh;

    // The first level of each stage reads that stage's input; others chain.
    if (i == 0) begin : g_first
      assign lvl_in[i] = stage_in[ST];
    end else if (level_stage(i - 1, nSTAGES, L) != ST) begin : g_head
      assign lvl_in[i] = stage_in[ST];
    end else begin : g_chain
      assign lvl_in[i] = lvl_out[i-1];
    end

    shift_level #(
      .nBITS(nBITS),
      .DIST (DIST)
    ) u_level (
      .data_i (lvl_in[i].data),
      .carry_i(lvl_in[i].ctrl.carry),
      .mode_i (lvl_in[i].ctrl.mode),
      .en_i   (lvl_in[i].amt[L-1-i]),
      .fill_i (lvl_in[i].ctrl.fill),
      .sign_i (lvl_in[i].ctrl.sign),
      .data_o (data_sh),
      .carry_o(carry_sh)
    );

    assign lvl_out[i] = '{
      data: data_sh,
      amt:  lvl_in[i].amt,
      ctrl: '{mode:  lvl_in[i].ctrl.mode,
              carry: carry_sh,
              fill:  lvl_in[i].ctrl.fill,
              sign:  lvl_in[i].ctrl.sign}
    };

    if (i == L - 1) begin : g_last
      assign stage_out[ST] = lvl_out[i];
    end else if (level_stage(i + 1, nSTAGES, L) != ST) begin : g_tail
      assign stage_out[ST] = lvl_out[i];
    end
  end

  // Stage s may move when any stage from s to the end is empty or the sink takes a beat.
  always_comb begin
    all_full = 1'b1;
    advance  = '0;
    for (int s = 0; s < nSTAGES; s++) begin
      all_full = 1'b1;
      for (int k = s; k < nSTAGES; k++) begin
        all_full = all_full & valid_q[k];
      end
      advance[s] = ~all_full | OutReady;
    end
  end

  assign InReady  = ready_en_q & advance[0];
  assign valid_in = {valid_q, InValid & InReady};

  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    for (int s = 0; s < nSTAGES; s++) begin
      if (advance[s]) begin
        valid_d[s] = valid_in[s];
        if (valid_in[s]) pay_d[s] = stage_out[s];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q    <= '0;
      ready_en_q <= 1'b0;
      // NOTE: payload flops are reset too because Out and CarryOut must read 0 during reset.
      for (int s = 0; s < nSTAGES; s++) pay_q[s] <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its neighbour's pre-edge value.
      valid_q    <= valid_d;
      ready_en_q <= 1'b1;
      pay_q      <= pay_d;
    end
  end

  assign OutValid = valid_q[nSTAGES-1];
  assign Out      = pay_q[nSTAGES-1].data;
  assign CarryOut = pay_q[nSTAGES-1].ctrl.carry;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (nBITS=32, nSTAGES=2): directed
// vectors, backpressure, mid-stream reset and a random run against a reference model.
module tb_pipelined_barrel_shifter;

  typedef struct packed {
    logic [31:0] d;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, shift_in, out_valid, out_ready, carry_out;
  logic [31:0] in_data, out_data;
  logic [4:0]  amt;
  logic [2:0]  mode;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   rnd_done = 1'b0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.nBITS(32), .nSTAGES(2)) dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .InValid    (in_valid),
    .InReady    (in_ready),
    .In         (in_data),
    .ShiftAmount(amt),
    .Mode       (mode),
    .ShiftIn    (shift_in),
    .OutValid   (out_valid),
    .OutReady   (out_ready),
    .Out        (out_data),
    .CarryOut   (carry_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [2:0] m, input int n, input logic [31:0] x,
                                 input logic si);
    exp_t        r;
    logic [31:0] hi_mask, lo_mask;
    hi_mask = ~(32'hFFFF_FFFF >> n);
    lo_mask = (32'h1 << n) - 32'h1;
    r.c = 1'b0;
    case (m)
      3'd1: begin
        r.d = (x >> n) | (si ? hi_mask : 32'h0);
        if (n != 0) r.c = x[n-1];
      end
      3'd2: begin
        r.d = $signed(x) >>> n;
        if (n != 0) r.c = x[n-1];
      end
      3'd3: begin
        r.d = (x << n) | (x >> (32 - n));
        if (n != 0) r.c = r.d[0];
      end
      3'd4: begin
        r.d = (x >> n) | (x << (32 - n));
        if (n != 0) r.c = r.d[31];
      end
      default: begin
        r.d = (x << n) | (si ? lo_mask : 32'h0);
        if (n != 0) r.c = x[32-n];
      end
    endcase
    return r;
  endfunction

  // Monitor: a beat is delivered on the coming edge when valid and ready hold at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {31'd0, out_data, carry_out}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", {31'd0, out_data, carry_out}, {31'd0, e.d, e.c});
        end
      end
    end
  end

  task automatic send(input logic [2:0] m, input logic [4:0] n, input logic [31:0] x,
                      input logic si, input exp_t e);
    int waited = 0;
    in_valid = 1'b1;
    mode     = m;
    amt      = n;
    in_data  = x;
    shift_in = si;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    amt       = '0;
    mode      = '0;
    shift_in  = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out_data), 64'd0);
    check("rst_carry", 64'(carry_out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", 64'(in_ready), 64'd1);

    // Directed vectors; the first also measures latency.
    send(3'd0, 5'd1, 32'h8000_0001, 1'b0, '{d: 32'h0000_0002, c: 1'b1});
    @(negedge clk);
    check("latency_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_cycle2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    send(3'd0, 5'd4,  32'h8000_0001, 1'b1, '{d: 32'h0000_001F, c: 1'b0});
    send(3'd2, 5'd4,  32'h8000_00F0, 1'b0, '{d: 32'hF800_000F, c: 1'b0});
    send(3'd1, 5'd4,  32'h8000_00F0, 1'b0, '{d: 32'h0800_000F, c: 1'b0});
    send(3'd4, 5'd1,  32'h0000_0001, 1'b0, '{d: 32'h8000_0000, c: 1'b1});
    send(3'd3, 5'd31, 32'h8000_0000, 1'b0, '{d: 32'h4000_0000, c: 1'b0});
    send(3'd2, 5'd0,  32'hDEAD_BEEF, 1'b1, '{d: 32'hDEAD_BEEF, c: 1'b0});
    send(3'd3, 5'd0,  32'hCAFE_F00D, 1'b0, '{d: 32'hCAFE_F00D, c: 1'b0});
    send(3'd0, 5'd0,  32'h1234_5678, 1'b1, '{d: 32'h1234_5678, c: 1'b0});
    send(3'd5, 5'd4,  32'h0000_000F, 1'b1, '{d: 32'h0000_00FF, c: 1'b0});
    send(3'd7, 5'd1,  32'h8000_0000, 1'b0, '{d: 32'h0000_0000, c: 1'b1});
    send(3'd6, 5'd2,  32'h4000_0001, 1'b0, '{d: 32'h0000_0004, c: 1'b1});
    drain();

    // Backpressure: two beats fill the pipe, the sink stalls for four cycles.
    out_ready = 1'b0;
    send(3'd0, 5'd31, 32'h0000_0001, 1'b0, '{d: 32'h8000_0000, c: 1'b0});
    send(3'd1, 5'd31, 32'h0000_0000, 1'b1, '{d: 32'hFFFF_FFFE, c: 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_stable", {31'd0, out_data, carry_out}, {31'd0, 32'h8000_0000, 1'b0});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd2, 5'd31, 32'h7FFF_FFFF, 1'b0, '{d: 32'h0000_0000, c: 1'b1});
    send(3'd4, 5'd4,  32'h1234_5678, 1'b0, '{d: 32'h8123_4567, c: 1'b1});
    send(3'd3, 5'd8,  32'h1234_5678, 1'b0, '{d: 32'h3456_7812, c: 1'b0});
    drain();

    // Reset with two beats in flight; junk presented while in reset must be ignored.
    send(3'd0, 5'd3, 32'h0000_0011, 1'b0, '{d: 32'h0000_0088, c: 1'b0});
    send(3'd1, 5'd3, 32'h0000_0011, 1'b0, '{d: 32'h0000_0002, c: 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", 64'(out_data), 64'd0);
    check("midrst_carry", 64'(carry_out), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    amt      = 5'd7;
    mode     = 3'd3;
    @(posedge clk);
    #1;
    in_data  = 32'h0BAD_0BAD;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_beat", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(3'd4, 5'd16, 32'hAAAA_5555, 1'b0, '{d: 32'h5555_AAAA, c: 1'b0});
    @(negedge clk);
    check("post_rst_latency1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("post_rst_latency2", 64'(out_valid), 64'd1);
    drain();

    // Random traffic with a ~75% sink duty cycle.
    fork
      begin
        logic [2:0]  m;
        logic [4:0]  n;
        logic [31:0] x;
        logic        si;
        for (int i = 0; i < 10000; i++) begin
          m  = 3'($urandom_range(0, 7));
          n  = 5'($urandom_range(0, 31));
          x  = $urandom;
          si = 1'($urandom_range(0, 1));
          send(m, n, x, si, model(m, n, x, si));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor of the single-cycle combinational left shifter.
- Supports five modes: logical left, logical right, arithmetic right, rotate left, rotate right.
- Produces a carry-out: the last bit shifted out.
- Wraps the log2(nBITS) mux levels in nSTAGES registered stages with valid/ready flow control. Sits between the ALU operand issue and writeback in the datapath.

Parameters:
- nBITS, 32, data width; power of two, >= 4.
- nSTAGES, 2, number of pipeline register stages; 1..$clog2(nBITS).

Ports:
- Clock  input  1  sole clock, rising edge
- Reset_n  input  1  asynchronous, active-low reset
- InValid  input  1  input beat valid
- InReady  output  1  shifter can accept a beat this cycle
- In  input  nBITS  operand
- ShiftAmount  input  $clog2(nBITS)  shift distance 0..nBITS-1
- Mode  input  3  shift_mode_t: SLL=0, SRL=1, SRA=2, ROL=3, ROR=4; 5..7 reserved
- ShiftIn  input  1  fill bit for SLL/SRL
- OutValid  output  1  result valid
- OutReady  input  1  downstream accepts result
- Out  output  nBITS  shifted result
- CarryOut  output  1  last bit shifted or rotated out; 0 when ShiftAmount=0

Behaviour:
- Clock and reset: one clock. Reset_n is asynchronous, active-low.
- While Reset_n=0, all stage valids clear immediately (not at the next edge):
  - OutValid=0, Out=0, CarryOut=0.
  - InReady=0 during reset, 1 from the first cycle after release.
- A beat is accepted on a rising edge with InValid&&InReady. A beat is delivered on a rising edge with OutValid&&OutReady.
- Latency: exactly nSTAGES cycles from acceptance to OutValid when not stalled. Throughput is 1 beat/cycle when OutReady=1.
- Mux levels:
  - Level i (i=0..L-1, L=$clog2(nBITS)) shifts by 2^(L-1-i), controlled by ShiftAmount[L-1-i]. Largest distance first.
  - Level i is placed combinationally in stage floor(i*nSTAGES/L). Each stage ends in a register.
- Per-stage register contents: valid bit, data, carry, Mode, remaining ShiftAmount bits, ShiftIn, and sign (In[nBITS-1], captured at entry).
- Elastic pipeline:
  - Stage s advances when it is empty or stage s+1 advances. The last stage advances when OutValid=0 or OutReady=1.
  - InReady = stage 0 advances. InReady is combinational from OutReady through the stage valids.
  - No bubble insertion; no beat loss or duplication.
  - Under a stall, Out and CarryOut stay stable.
- Fill and wrap per level:
  - SLL/SRL vacated bits take ShiftIn.
  - SRA vacated bits take the captured sign.
  - ROL/ROR wrap the bits around; ShiftIn is ignored.
- Carry rule:
  - Carry is 0 at entry. Each level whose amount bit is 1 overwrites carry with the last bit it moves out.
  - Left modes: input bit nBITS-2^k. Right modes: input bit 2^k-1.
  - Net results (n = ShiftAmount): SLL gives In[nBITS-n]; SRL/SRA give In[n-1]; ROL gives Out[0]; ROR gives Out[nBITS-1].
- Reserved Mode values behave as SLL. This is a defined, tested behaviour.
- Inputs are sampled only on acceptance. Changing inputs while InReady=0 has no effect.
- Reset mid-stream: all in-flight beats are discarded; nothing is delivered after reset release until new beats are accepted.

Decomposition:
- Package shifter_pkg: shift_mode_t enum (3 bits), stage payload struct, localparam helper for the level-to-stage mapping function.
- Sub-module shift_level: combinational, parameters nBITS and DIST. Inputs: data, carry, mode, enable, fill, sign. Outputs: data, carry.
- Top instantiates L shift_levels via generate, plus nSTAGES payload registers with valid and stall logic.

Test Plan (nBITS=32, nSTAGES=2):
- SLL: In=0x8000_0001, amt 1, ShiftIn=0 -> after 2 cycles Out=0x0000_0002, CarryOut=1. Same beat with ShiftIn=1, amt 4 -> Out=0x0000_001F, CarryOut=0.
- SRA: In=0x8000_00F0, amt 4 -> Out=0xF800_000F, CarryOut=0. SRL same beat, ShiftIn=0 -> Out=0x0800_000F.
- Rotates and zero shift:
  - ROR In=0x0000_0001, amt 1 -> Out=0x8000_0000, CarryOut=1.
  - ROL In=0x8000_0000, amt 31 -> Out=0x4000_0000, CarryOut=0.
  - Any mode with amt 0 -> Out=In, CarryOut=0.
- Backpressure: 5 back-to-back beats, OutReady held low 4 cycles -> InReady drops after 2 beats are resident. All 5 results emerge in order, none lost or duplicated, Out stable while stalled.
- Reset mid-stream: assert Reset_n=0 with 2 beats in flight -> OutValid=0 asynchronously. After release, no stale beat appears; a new beat returns after exactly 2 cycles.
- Random scoreboard: 10k random Mode/amt/In/ShiftIn with random OutReady duty -> matches reference model for Out and CarryOut; reserved Mode values behave as SLL.
